// File: rtl/op_pkg.sv
// Shared definitions for the opcode fetch unit.
//   OP_W      : opcode width (matches opram dout)
//   ADDR_W    : opram address width
//   RD_LAT    : address-to-dout latency of the opram
//   BUF_DEPTH : result buffer entries (>= RD_LAT+1)
//   state_t   : fetch sequencer states
package op_pkg;

  localparam int OP_W      = 8;
  localparam int ADDR_W    = 3;
  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/op_fetch_fifo.sv
// Synchronous result buffer for op_fetch.
//   clk, rst     : clock, synchronous active-high reset
//   i_flush      : empty the buffer this cycle (wins over push/pop)
//   i_push       : write i_push_data
//   i_pop        : remove the head entry
//   o_pop_data   : head entry, zero while empty
//   o_empty      : no entries held
//   o_count      : number of entries held
module op_fetch_fifo #(
  parameter  int DATA_W = 11,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop_ok);
  // Head is forced to zero when empty so stale entries never leak out.
  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/op_fetch.sv
// Opcode fetch unit: issues reads to the opram, absorbs its read latency and
// hands opcodes to the executor over a valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   start, start_addr    : begin fetching at start_addr (IDLE/DONE only)
//   halt                 : stop issuing, drain, return to IDLE
//   loop_en              : wrap after the last address instead of stopping
//   jmp_valid, jmp_target: redirect fetch, discarding in-flight/buffered ops
//   mem_addr, mem_oce    : opram address and output clock enable
//   mem_dout             : opram read data
//   op_valid, op_ready   : executor handshake
//   op_data, op_pc       : delivered opcode and its address
//   busy                 : RUN or DRAIN
module op_fetch #(
  parameter int OP_W      = op_pkg::OP_W,
  parameter int ADDR_W    = op_pkg::ADDR_W,
  parameter int RD_LAT    = op_pkg::RD_LAT,
  parameter int BUF_DEPTH = op_pkg::BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              halt,
  input  logic              loop_en,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oce,
  input  logic [OP_W-1:0]   mem_dout,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [OP_W-1:0]   op_data,
  output logic [ADDR_W-1:0] op_pc,
  output logic              busy
);

  import op_pkg::*;

  localparam int CW  = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;
  localparam int FCW = $clog2(BUF_DEPTH + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                r_halted;
  logic                w_halted_nxt;
  logic                w_issue;
  logic                w_flush;
  logic                w_credit;
  logic                w_pop;
  logic                w_empty;
  logic [CW-1:0]       w_inflight;
  logic [FCW-1:0]      w_fifo_count;
  logic [RD_LAT-1:0]   r_tag_v;
  logic [ADDR_W-1:0]   r_tag_pc [RD_LAT];
  logic [OP_W+ADDR_W-1:0] w_head;

  assign mem_addr = r_pc;
  assign busy     = (r_state == RUN) || (r_state == DRAIN);
  assign mem_oce  = busy;
  assign op_valid = !w_empty;
  assign w_pop    = op_valid && op_ready;
  assign op_data  = w_head[ADDR_W +: OP_W];
  assign op_pc    = w_head[ADDR_W-1:0];

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_tag_v[i]);
  end

  // Every issued read already owns a buffer slot, so the buffer cannot overflow.
  assign w_credit = (w_inflight + CW'(w_fifo_count)) < CW'(BUF_DEPTH);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_halted_nxt = r_halted;
    w_issue      = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt  = RUN;
          w_pc_nxt     = start_addr;
          w_halted_nxt = 1'b0;
        end
      end
      RUN: begin
        if (jmp_valid) begin
          w_flush  = 1'b1;
          w_pc_nxt = jmp_target;
        end else if (halt) begin
          w_state_nxt  = DRAIN;
          w_halted_nxt = 1'b1;
        end else if (w_credit) begin
          w_issue  = 1'b1;
          w_pc_nxt = r_pc + 1'b1;
          if ((r_pc == '1) && !loop_en) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (jmp_valid) begin
          w_flush      = 1'b1;
          w_pc_nxt     = jmp_target;
          w_state_nxt  = RUN;
          w_halted_nxt = 1'b0;
        end else if ((w_inflight == '0) && w_empty) begin
          w_state_nxt = r_halted ? IDLE : DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // Tag pipe mirrors the opram latency; the last stage marks mem_dout as ours.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_tag_v <= '0;
    end else begin
      r_tag_v[0] <= w_issue;
      for (int unsigned i = 1; i < RD_LAT; i++) r_tag_v[i] <= r_tag_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_tag_pc[0] <= r_pc;
    for (int unsigned i = 1; i < RD_LAT; i++) r_tag_pc[i] <= r_tag_pc[i-1];
  end

  op_fetch_fifo #(
    .DATA_W (OP_W + ADDR_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_flush),
    .i_push      (r_tag_v[RD_LAT-1]),
    .i_push_data ({mem_dout, r_tag_pc[RD_LAT-1]}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_empty     (w_empty),
    .o_count     (w_fifo_count)
  );

endmodule

// File: tb/tb_op_fetch.sv
module tb_op_fetch;

  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] start_addr;
  logic       halt;
  logic       loop_en;
  logic       jmp_valid;
  logic [2:0] jmp_target;
  logic [2:0] mem_addr;
  logic       mem_oce;
  logic [7:0] mem_dout;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_data;
  logic [2:0] op_pc;
  logic       busy;

  op_fetch #(
    .OP_W      (8),
    .ADDR_W    (3),
    .RD_LAT    (RD_LAT),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .halt       (halt),
    .loop_en    (loop_en),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .mem_addr   (mem_addr),
    .mem_oce    (mem_oce),
    .mem_dout   (mem_dout),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_data    (op_data),
    .op_pc      (op_pc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // opram: address sampled on the clock, data appears RD_LAT edges later
  logic [7:0] ram [8];
  logic [7:0] mpipe [RD_LAT];
  initial for (int i = 0; i < 8; i++) ram[i] = 8'h10 + 8'(i);
  always @(posedge clk) begin
    mpipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mem_dout = mpipe[RD_LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pc  = 0;   // next program address the executor must receive
  int n_acc   = 0;
  int issued  = 0;   // reads issued, seen as mem_addr advancing

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: score the handshake of this cycle, apply the program-order rules
  // for start/jump, then sample #1 after the edge.
  task automatic tick();
    logic       pv, pr, pj, prst, pbusy;
    logic [7:0] pd;
    logic [2:0] pp, pa;
    pv = op_valid; pr = op_ready; pj = jmp_valid; prst = rst; pbusy = busy;
    pd = op_data; pp = op_pc; pa = mem_addr;
    if (pv && pr && !prst) begin
      check_eq("acc_pc", 32'(pp), 32'(exp_pc));
      check_eq("acc_data", 32'(pd), 32'(8'h10 + 8'(exp_pc)));
      exp_pc = (exp_pc + 1) % 8;
      n_acc++;
    end
    if (!prst && pbusy && pj) exp_pc = int'(jmp_target);
    else if (!prst && !pbusy && start) exp_pc = int'(start_addr);
    @(posedge clk);
    #1;
    if (mem_addr != pa) issued++;
    if (pv && !pr && !pj && !prst) begin
      check_eq("hold_valid", 32'(op_valid), 32'd1);
      check_eq("hold_data", {21'd0, op_pc, op_data}, {21'd0, pp, pd});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; jmp_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] a, input logic le);
    start_addr = a; loop_en = le; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain_to_idle(input string tag);
    int c = 0;
    halt = 1'b1; tick(); halt = 1'b0;
    while (busy && c < 40) begin tick(); c++; end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int gaps, c, base;
    logic seen;
    logic [2:0] a_h;
    rst = 1'b1; start = 1'b0; start_addr = '0; halt = 1'b0; loop_en = 1'b0;
    jmp_valid = 1'b0; jmp_target = '0; op_ready = 1'b0;

    // reset values
    tick(); tick(); tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(op_valid), 32'd0);
    check_eq("rst_oce", 32'(mem_oce), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_data", 32'(op_data), 32'd0);
    check_eq("rst_pc", 32'(op_pc), 32'd0);
    rst = 1'b0;

    // 1: single pass 0..7, back-to-back, then DONE
    op_ready = 1'b1; n_acc = 0; gaps = 0; seen = 1'b0; c = 0;
    pulse_start(3'd0, 1'b0);
    while ((busy || op_valid) && c < 60) begin
      tick(); c++;
      if (op_valid) seen = 1'b1;
      else if (seen && n_acc < 8) gaps++;
    end
    check_eq("t1_count", 32'(n_acc), 32'd8);
    check_eq("t1_gaps", 32'(gaps), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_valid", 32'(op_valid), 32'd0);

    // 2: looping, 20 accepts with no bubbles, restarted from DONE
    n_acc = 0; gaps = 0; seen = 1'b0; c = 0;
    pulse_start(3'd0, 1'b1);
    while (n_acc < 20 && c < 80) begin
      tick(); c++;
      if (op_valid) seen = 1'b1;
      else if (seen && n_acc < 20) gaps++;
    end
    check_eq("t2_count", 32'(n_acc), 32'd20);
    check_eq("t2_gaps", 32'(gaps), 32'd0);
    drain_to_idle("t2_idle");

    // 3: executor stall after the first op
    do_reset();
    issued = 0; n_acc = 0; op_ready = 1'b0; c = 0;
    pulse_start(3'd0, 1'b1);
    while (!op_valid && c < 20) begin tick(); c++; end
    check_eq("t3_first_data", 32'(op_data), 32'h10);
    check_eq("t3_first_pc", 32'(op_pc), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t3_stall_data", 32'(op_data), 32'h10);
      check_eq("t3_outstanding", 32'((issued - n_acc) <= BUF_DEPTH), 32'd1);
    end
    op_ready = 1'b1; c = 0;
    while (n_acc < 12 && c < 60) begin
      tick(); c++;
      check_eq("t3_outstanding", 32'((issued - n_acc) <= BUF_DEPTH), 32'd1);
    end
    check_eq("t3_count", 32'(n_acc), 32'd12);
    drain_to_idle("t3_idle");

    // 4: jump to 5 while pc=2 with two reads in flight
    do_reset();
    n_acc = 0; op_ready = 1'b1; c = 0;
    pulse_start(3'd0, 1'b1);
    while (mem_addr != 3'd2 && c < 10) begin tick(); c++; end
    check_eq("t4_pc_reached", 32'(mem_addr), 32'd2);
    jmp_target = 3'd5; jmp_valid = 1'b1;
    tick();
    jmp_valid = 1'b0;
    check_eq("t4_valid_after_jmp", 32'(op_valid), 32'd0);
    c = 0;
    while (!op_valid && c < 20) begin tick(); c++; end
    check_eq("t4_first_pc", 32'(op_pc), 32'd5);
    check_eq("t4_first_data", 32'(op_data), 32'h15);
    c = 0;
    while (n_acc < 6 && c < 40) begin tick(); c++; end
    check_eq("t4_count", 32'(n_acc), 32'd6);
    drain_to_idle("t4_idle");

    // 5: halt after three accepts
    do_reset();
    n_acc = 0; op_ready = 1'b1; c = 0;
    pulse_start(3'($urandom_range(0, 1)), 1'b0);
    while (n_acc < 3 && c < 30) begin tick(); c++; end
    halt = 1'b1; tick(); halt = 1'b0;
    a_h = mem_addr; base = n_acc; c = 0;
    while (busy && c < 30) begin tick(); c++; end
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_inflight_delivered", 32'(n_acc > base), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t5_addr_frozen", 32'(mem_addr), 32'(a_h));
      check_eq("t5_valid", 32'(op_valid), 32'd0);
    end

    // 6: reset mid-run with a full buffer
    do_reset();
    n_acc = 0; op_ready = 1'b0;
    pulse_start(3'd3, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    check_eq("t6_full_valid", 32'(op_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t6_valid", 32'(op_valid), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_oce", 32'(mem_oce), 32'd0);
    check_eq("t6_addr", 32'(mem_addr), 32'd0);
    check_eq("t6_data", 32'(op_data), 32'd0);
    check_eq("t6_pc", 32'(op_pc), 32'd0);
    op_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check_eq("t6_no_ops", 32'(n_acc), 32'd0);

    // 7: random ready/jump traffic against the program-order model
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      pulse_start(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 150; i++) begin
        op_ready   = ($urandom_range(0, 3) != 0);
        jmp_valid  = ($urandom_range(0, 19) == 0);
        jmp_target = 3'($urandom_range(0, 7));
        tick();
      end
      jmp_valid = 1'b0; op_ready = 1'b1;
      drain_to_idle("t7_idle");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
